// File: rtl/dbus_fifo_pkg.sv
// Shared register map for the data-bus FIFO responder: window offsets,
// STATUS layout, CONTROL bit positions and the default window base.
// Latency: n/a (definitions only). Backpressure: n/a.
package dbus_fifo_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFF20_0000;

    // Register selected by address bits [3:2] inside the 16-byte window.
    typedef enum logic [1:0] {
        REG_TXDATA  = 2'd0,   // offset 0x0, write-only
        REG_RXDATA  = 2'd1,   // offset 0x4, read-only (pops RX)
        REG_STATUS  = 2'd2,   // offset 0x8, read-only
        REG_CONTROL = 2'd3    // offset 0xC, write-only
    } reg_sel_e;

    // Count fields are 5 bits wide so DEPTH=16 (count 0..16) fits.
    localparam int CNT_W = 5;

    // STATUS register, MSB first; field order fixes the bit positions:
    // [4:0] tx_count, [9:5] rx_count, [10] tx_full, [11] tx_empty,
    // [12] tx_overflow, [13] rx_underflow, [14] rx_full, [15] rx_empty,
    // [16] irq_en, [31:17] zero.
    typedef struct packed {
        logic [14:0]      rsvd;
        logic             irq_en;
        logic             rx_empty;
        logic             rx_full;
        logic             rx_underflow;
        logic             tx_overflow;
        logic             tx_empty;
        logic             tx_full;
        logic [CNT_W-1:0] rx_count;
        logic [CNT_W-1:0] tx_count;
    } status_t;

    // CONTROL write bits; any combination may be set in one write.
    localparam int CT_FLUSH_TX   = 0;
    localparam int CT_FLUSH_RX   = 1;
    localparam int CT_IRQ_EN     = 2;
    localparam int CT_CLR_STICKY = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; head is a combinational view of the oldest entry.
// Latency: a push is visible at head one edge later; pop/push/flush take effect at the edge.
// Backpressure: push ignored while full (pre-edge), pop ignored while empty; flush beats both.
// Ports: clk, rst (sync active-high), push/wr_data, pop, flush, full, empty, count, head.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    // Both qualifiers use pre-edge state: a pop on a full FIFO does not
    // make room for a push on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dbus_fifo_responder.sv
// Memory-mapped TX/RX FIFO pair on the CPU data bus, bridging to valid/ready streams.
// Latency: zero-wait-state reads (combinational DwReadData); writes and stream transfers act at the edge.
// Backpressure: TX writes while full are dropped (tx_overflow); RX reads while empty return 0 (rx_underflow); oRxReady=!rx_full.
// Ports: iCLK/iRST (sync active-high), Dw* data-bus slave, oTx*/iTxReady TX stream, iRx*/oRxReady RX stream,
// oIRQ only when DBUS_FIFO_IRQ_EN is defined (default build has no interrupt and STATUS[16] reads 0).
module dbus_fifo_responder
    import dbus_fifo_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          DEPTH     = 8
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        DwReadEnable,
    input  logic        DwWriteEnable,
    input  logic [3:0]  DwByteEnable,
    input  logic [31:0] DwAddress,
    input  logic [31:0] DwWriteData,
    output logic [31:0] DwReadData,
    output logic        oTxValid,
    output logic [31:0] oTxData,
    input  logic        iTxReady,
    input  logic        iRxValid,
    input  logic [31:0] iRxData,
    output logic        oRxReady
`ifdef DBUS_FIFO_IRQ_EN
    ,
    output logic        oIRQ
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Address decode
    logic     sel;
    reg_sel_e reg_sel;
    logic     full_wr;
    logic     tx_wr;
    logic     ctl_wr;
    logic     rx_rd;
    logic     unused_addr_lsbs;

    assign sel              = (DwAddress[31:4] == BASE_ADDR[31:4]);
    assign reg_sel          = reg_sel_e'(DwAddress[3:2]);
    // Only full-word writes have any effect.
    assign full_wr          = DwWriteEnable && sel && (DwByteEnable == 4'b1111);
    assign tx_wr            = full_wr && (reg_sel == REG_TXDATA);
    assign ctl_wr           = full_wr && (reg_sel == REG_CONTROL);
    assign rx_rd            = DwReadEnable && sel && (reg_sel == REG_RXDATA);
    assign unused_addr_lsbs = ^DwAddress[1:0];

    // FIFOs
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0] tx_count, rx_count;
    logic [31:0]   rx_head;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk     (iCLK),
        .rst     (iRST),
        .push    (tx_wr),
        .wr_data (DwWriteData),
        .pop     (oTxValid && iTxReady),
        .flush   (ctl_wr && DwWriteData[CT_FLUSH_TX]),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count),
        .head    (oTxData)
    );

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk     (iCLK),
        .rst     (iRST),
        .push    (iRxValid && oRxReady),
        .wr_data (iRxData),
        .pop     (rx_rd),
        .flush   (ctl_wr && DwWriteData[CT_FLUSH_RX]),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count),
        .head    (rx_head)
    );

    assign oTxValid = !tx_empty;
    assign oRxReady = !rx_full;

    // Sticky error flags. A clear and a new error on the same edge leave
    // the flag set so the new error is not lost.
    logic tx_overflow;
    logic rx_underflow;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
        end else begin
            if (ctl_wr && DwWriteData[CT_CLR_STICKY]) begin
                tx_overflow  <= 1'b0;
                rx_underflow <= 1'b0;
            end
            if (tx_wr && tx_full) begin
                tx_overflow <= 1'b1;
            end
            if (rx_rd && rx_empty) begin
                rx_underflow <= 1'b1;
            end
        end
    end

    // Interrupt
    logic irq_en;

`ifdef DBUS_FIFO_IRQ_EN
    // oIRQ is registered from the current flag values, so it follows its
    // cause by one edge.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            irq_en <= 1'b0;
            oIRQ   <= 1'b0;
        end else begin
            if (ctl_wr) begin
                irq_en <= DwWriteData[CT_IRQ_EN];
            end
            oIRQ <= irq_en && (!rx_empty || tx_overflow);
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    // Read mux
    status_t status;

    always_comb begin
        status              = '0;
        status.tx_count     = CNT_W'(tx_count);
        status.rx_count     = CNT_W'(rx_count);
        status.tx_full      = tx_full;
        status.tx_empty     = tx_empty;
        status.tx_overflow  = tx_overflow;
        status.rx_underflow = rx_underflow;
        status.rx_full      = rx_full;
        status.rx_empty     = rx_empty;
        status.irq_en       = irq_en;
    end

    always_comb begin
        DwReadData = 32'h0;
        if (DwReadEnable && sel) begin
            case (reg_sel)
                REG_RXDATA: DwReadData = rx_empty ? 32'h0 : rx_head;
                REG_STATUS: DwReadData = status;
                default:    DwReadData = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_fifo_responder.sv
// Testbench for dbus_fifo_responder: directed bus/stream vectors with a scoreboard
// holding expected bus-read data and expected TX stream words; a negedge monitor
// compares whenever a read strobe or a TX handshake is present.
module tb_dbus_fifo_responder;

    localparam logic [31:0] BASE = 32'hFF20_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_RX = BASE + 32'h4;
    localparam logic [31:0] A_ST = BASE + 32'h8;
    localparam logic [31:0] A_CT = BASE + 32'hC;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        DwReadEnable;
    logic        DwWriteEnable;
    logic [3:0]  DwByteEnable;
    logic [31:0] DwAddress;
    logic [31:0] DwWriteData;
    logic [31:0] DwReadData;
    logic        oTxValid;
    logic [31:0] oTxData;
    logic        iTxReady;
    logic        iRxValid;
    logic [31:0] iRxData;
    logic        oRxReady;
`ifdef DBUS_FIFO_IRQ_EN
    logic        oIRQ;
`endif

    dbus_fifo_responder #(
        .BASE_ADDR (BASE),
        .DEPTH     (8)
    ) dut (
        .iCLK          (iCLK),
        .iRST          (iRST),
        .DwReadEnable  (DwReadEnable),
        .DwWriteEnable (DwWriteEnable),
        .DwByteEnable  (DwByteEnable),
        .DwAddress     (DwAddress),
        .DwWriteData   (DwWriteData),
        .DwReadData    (DwReadData),
        .oTxValid      (oTxValid),
        .oTxData       (oTxData),
        .iTxReady      (iTxReady),
        .iRxValid      (iRxValid),
        .iRxData       (iRxData),
        .oRxReady      (oRxReady)
`ifdef DBUS_FIFO_IRQ_EN
        ,
        .oIRQ          (oIRQ)
`endif
    );

    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rd_exp [$];
    string       rd_nm  [$];
    logic [31:0] tx_exp [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: bus reads and TX handshakes are checked against the queues.
    initial begin
        forever begin
            @(negedge iCLK);
            if (!iRST) begin
                if (DwReadEnable) begin
                    if (rd_exp.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_read: got 0x%08h, expected no read", DwReadData);
                    end else begin
                        check(rd_nm.pop_front(), DwReadData, rd_exp.pop_front());
                    end
                end
                if (oTxValid && iTxReady) begin
                    if (tx_exp.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_tx: got 0x%08h, expected no TX word", oTxData);
                    end else begin
                        check("tx_stream", oTxData, tx_exp.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        DwWriteEnable = 1'b1;
        DwAddress     = a;
        DwWriteData   = d;
        DwByteEnable  = be;
        tick();
        DwWriteEnable = 1'b0;
        DwByteEnable  = 4'b0000;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string nm);
        rd_exp.push_back(e);
        rd_nm.push_back(nm);
        DwReadEnable = 1'b1;
        DwAddress    = a;
        tick();
        DwReadEnable = 1'b0;
    endtask

    task automatic rx_push(input logic [31:0] d);
        iRxValid = 1'b1;
        iRxData  = d;
        tick();
        iRxValid = 1'b0;
    endtask

    initial begin
        iRST          = 1'b1;
        DwReadEnable  = 1'b0;
        DwWriteEnable = 1'b0;
        DwByteEnable  = 4'b0000;
        DwAddress     = 32'h0;
        DwWriteData   = 32'h0;
        iTxReady      = 1'b0;
        iRxValid      = 1'b0;
        iRxData       = 32'h0;
        repeat (2) tick();
        iRST = 1'b0;

        // Reset state
        check("rst_tx_valid", {31'b0, oTxValid}, 32'h0);
        check("rst_rx_ready", {31'b0, oRxReady}, 32'h1);
        bus_read(A_ST, 32'h0000_8800, "rst_status");

        // Single TX write
        bus_write(A_TX, 32'hDEAD_BEEF, 4'hF);
        tx_exp.push_back(32'hDEAD_BEEF);
        check("tx1_valid", {31'b0, oTxValid}, 32'h1);
        check("tx1_data", oTxData, 32'hDEAD_BEEF);
        bus_read(A_ST, 32'h0000_8001, "tx1_status");
        iTxReady = 1'b1;
        tick();
        iTxReady = 1'b0;

        // TX overflow: 9 writes into 8 entries, then drain in order
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) tx_exp.push_back(32'(i));
            bus_write(A_TX, 32'(i), 4'hF);
        end
        bus_read(A_ST, 32'h0000_9408, "txfull_status");
        iTxReady = 1'b1;
        repeat (8) tick();
        iTxReady = 1'b0;
        check("txdrain_valid", {31'b0, oTxValid}, 32'h0);
        bus_read(A_ST, 32'h0000_9800, "txdrain_status");
        bus_write(A_CT, 32'h8, 4'hF);
        bus_read(A_ST, 32'h0000_8800, "txclr_status");

        // RX reads with underflow
        rx_push(32'h11);
        rx_push(32'h22);
        bus_read(A_ST, 32'h0000_0840, "rx2_status");
        bus_read(A_RX, 32'h11, "rx_read0");
        bus_read(A_RX, 32'h22, "rx_read1");
        bus_read(A_RX, 32'h0, "rx_read_empty");
        bus_read(A_ST, 32'h0000_A800, "rxunder_status");
        bus_write(A_CT, 32'h8, 4'hF);
        bus_read(A_ST, 32'h0000_8800, "rxclr_status");

        // Partial write, decode and read-enable gating
        bus_write(A_TX, 32'h0000_CAFE, 4'b0011);
        check("partial_tx_valid", {31'b0, oTxValid}, 32'h0);
        bus_read(A_ST, 32'h0000_8800, "partial_status");
        bus_read(32'h0000_1000, 32'h0, "unselected_read");
        bus_read(A_TX, 32'h0, "txdata_read");
        bus_read(A_CT, 32'h0, "control_read");
        DwAddress = A_ST;
        #1;
        check("read_disabled", DwReadData, 32'h0);

        // TX full with concurrent pop and write, then flush with concurrent pop
        for (int i = 0; i < 8; i++) begin
            tx_exp.push_back(32'hA0 + 32'(i));
            bus_write(A_TX, 32'hA0 + 32'(i), 4'hF);
        end
        iTxReady = 1'b1;
        bus_write(A_TX, 32'h0000_0BAD, 4'hF);
        iTxReady = 1'b0;
        bus_read(A_ST, 32'h0000_9007, "fullpop_status");
        iTxReady = 1'b1;
        bus_write(A_CT, 32'h1, 4'hF);
        iTxReady = 1'b0;
        tx_exp.delete();
        check("flush_tx_valid", {31'b0, oTxValid}, 32'h0);
        bus_read(A_ST, 32'h0000_9800, "flush_status");
        bus_write(A_CT, 32'h8, 4'hF);
        bus_read(A_ST, 32'h0000_8800, "flushclr_status");

        // RX full, simultaneous push/pop, flush
        for (int i = 0; i < 8; i++) rx_push(32'h100 + 32'(i));
        check("rxfull_ready", {31'b0, oRxReady}, 32'h0);
        bus_read(A_ST, 32'h0000_4900, "rxfull_status");
        iRxValid = 1'b1;
        iRxData  = 32'h999;
        bus_read(A_RX, 32'h100, "rxfull_pop");
        iRxValid = 1'b0;
        bus_read(A_ST, 32'h0000_08E0, "rxfull_pushdrop_status");
        iRxValid = 1'b1;
        iRxData  = 32'h200;
        bus_read(A_RX, 32'h101, "rx_pushpop");
        iRxValid = 1'b0;
        bus_read(A_ST, 32'h0000_08E0, "rx_pushpop_status");
        bus_read(A_RX, 32'h102, "rx_order");
        bus_write(A_CT, 32'h2, 4'hF);
        bus_read(A_ST, 32'h0000_8800, "rxflush_status");

        // Reset mid-stream with five entries in each FIFO
        for (int i = 0; i < 5; i++) bus_write(A_TX, 32'h300 + 32'(i), 4'hF);
        for (int i = 0; i < 5; i++) rx_push(32'h400 + 32'(i));
        bus_write(A_CT, 32'h4, 4'hF);
`ifdef DBUS_FIFO_IRQ_EN
        bus_read(A_ST, 32'h0001_00A5, "prerst_status");
        check("prerst_irq", {31'b0, oIRQ}, 32'h1);
`else
        bus_read(A_ST, 32'h0000_00A5, "prerst_status");
`endif
        iRST          = 1'b1;
        iRxValid      = 1'b1;
        iRxData       = 32'h555;
        DwWriteEnable = 1'b1;
        DwAddress     = A_TX;
        DwWriteData   = 32'h555;
        DwByteEnable  = 4'hF;
        tick();
        iRST          = 1'b0;
        iRxValid      = 1'b0;
        DwWriteEnable = 1'b0;
        DwByteEnable  = 4'h0;
        check("rst_mid_tx_valid", {31'b0, oTxValid}, 32'h0);
        check("rst_mid_rx_ready", {31'b0, oRxReady}, 32'h1);
`ifdef DBUS_FIFO_IRQ_EN
        check("rst_mid_irq", {31'b0, oIRQ}, 32'h0);
`endif
        bus_read(A_ST, 32'h0000_8800, "rst_mid_status");

        tick();
        check("tx_queue_left", 32'(tx_exp.size()), 32'h0);
        check("rd_queue_left", 32'(rd_exp.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dbus_fifo_responder.md
DBUS_FIFO_RESPONDER -- requirements
Module: dbus_fifo_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFF20_0000, which is the 16-byte-aligned base of the register window.
REQ-002 SHALL have parameter DEPTH, default 8, which is the entries per FIFO; it is a power of two, range 2..16.
REQ-003 SHALL have port iCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port iRST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port DwReadEnable, input, 1 bit: CPU data-bus read strobe.
REQ-006 SHALL have port DwWriteEnable, input, 1 bit: CPU data-bus write strobe.
REQ-007 SHALL have port DwByteEnable, input, 4 bits: write byte lanes.
REQ-008 SHALL have port DwAddress, input, 32 bits: byte address.
REQ-009 SHALL have port DwWriteData, input, 32 bits: write data.
REQ-010 SHALL have port DwReadData, output, 32 bits: read data, combinational from address and current state.
REQ-011 SHALL have port oTxValid, output, 1 bit, and port oTxData, output, 32 bits: TX stream head.
REQ-012 SHALL have port iTxReady, input, 1 bit: TX stream sink accepts.
REQ-013 SHALL have port iRxValid, input, 1 bit, and port iRxData, input, 32 bits: RX stream source.
REQ-014 SHALL have port oRxReady, output, 1 bit: RX FIFO can accept.

Function
REQ-015 SHALL select the window when DwAddress[31:4]==BASE_ADDR[31:4]; offsets are 0x0 TXDATA (W), 0x4 RXDATA (R), 0x8 STATUS (R), 0xC CONTROL (W).
REQ-016 SHALL drive DwReadData=0 for unselected addresses, for write-only offsets, and whenever DwReadEnable=0.
REQ-017 SHALL act on writes only when DwByteEnable==4'b1111; partial writes are ignored with no side effects.
REQ-018 SHALL push DwWriteData into the TX FIFO at the edge on which a TXDATA write occurs and TX is not full; if TX is full, data is dropped and STATUS[12] (tx_overflow, sticky) is set.
REQ-019 SHALL present the RX head on an RXDATA read with zero wait states and pop it at that edge; if RX is empty, the read returns 0, nothing is popped, and STATUS[13] (rx_underflow, sticky) is set.
REQ-020 SHALL lay out STATUS as [4:0] tx_count, [9:5] rx_count, [10] tx_full, [11] tx_empty, [12] tx_overflow, [13] rx_underflow, [14] rx_full, [15] rx_empty, [16] irq_en (0 without macro), [31:17] 0.
REQ-021 SHALL implement CONTROL writes as: bit0 flushes TX, bit1 flushes RX, bit2 loads irq_en, bit3 clears both sticky flags; any combination is allowed in one write.
REQ-022 SHALL set oTxValid=!tx_empty and oTxData=TX head; a pop occurs on each edge where oTxValid && iTxReady.
REQ-023 SHALL set oRxReady=!rx_full; a push of iRxData occurs on each edge where iRxValid && oRxReady.
REQ-024 SHALL, on a simultaneous push and pop on one FIFO, perform both: count unchanged, pointers advance. On a full FIFO, the pop frees the slot, but the push is still governed by pre-edge full.
REQ-025 SHALL give flush priority over a same-edge push or pop, leaving the FIFO empty.
REQ-026 SHALL wrap pointers modulo DEPTH; counts range 0..DEPTH.

Reset
REQ-027 SHALL, on iRST=1 at an edge, empty both FIFOs and clear the sticky flags and irq_en, which forces oTxValid=0, oRxReady=1, and oIRQ=0.
REQ-028 SHALL give reset priority over every same-edge bus or stream event; storage contents need not be cleared.

Configuration
REQ-029 SHALL, when macro DBUS_FIFO_IRQ_EN is defined, add output oIRQ (1 bit), registered, equal to irq_en && (!rx_empty || tx_overflow), updated one edge after its cause.
REQ-030 SHALL, without DBUS_FIFO_IRQ_EN, have no oIRQ port; CONTROL bit2 is ignored and STATUS[16] reads 0.

Structure
REQ-031 SHALL keep register offsets, STATUS/CONTROL bit positions, and the default BASE_ADDR in a shared package, dbus_fifo_pkg.
REQ-032 SHALL instantiate sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, flush, full, empty, count, head) twice.

Verification
REQ-033 SHALL verify: write 0xDEADBEEF to BASE+0 with iTxReady=0 -> oTxValid=1 next cycle, oTxData=0xDEADBEEF, STATUS[4:0]=1.
REQ-034 SHALL verify: 9 TXDATA writes with iTxReady=0 and DEPTH=8 -> tx_full=1, tx_overflow=1, 8 entries drained in order 1..8 once iTxReady=1.
REQ-035 SHALL verify: push 0x11, 0x22 on RX stream, then 3 reads of BASE+4 -> 0x11, 0x22, 0; rx_underflow=1; a CONTROL write of 0x8 clears it.
REQ-036 SHALL verify: a write of 0xCAFE with DwByteEnable=4'b0011 to BASE+0 -> TX stays empty; a read of 0x0000_1000 -> DwReadData=0.
REQ-037 SHALL verify: TX full with iTxReady=1 and a TXDATA write on the same edge -> one pop, write dropped, overflow set; a CONTROL write of 0x1 with a concurrent TX pop -> tx_count=0.
REQ-038 SHALL verify: iRST asserted mid-stream with 5 entries in each FIFO -> both FIFOs empty after the edge, STATUS=0x0000_8800, oIRQ=0 (with DBUS_FIFO_IRQ_EN).
